// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the VGA timing generator.
// The defaults describe 640x480 @ 60 Hz from a 100 MHz board clock.
package vga_timing_pkg;

  localparam int unsigned CNT_W = 16;

  localparam int unsigned DEF_CLK_DIV     = 4;
  localparam int unsigned DEF_H_TOTAL     = 800;
  localparam int unsigned DEF_H_SYNC      = 96;
  localparam int unsigned DEF_H_VIS_START = 144;
  localparam int unsigned DEF_H_VIS_END   = 784;
  localparam int unsigned DEF_V_TOTAL     = 525;
  localparam int unsigned DEF_V_SYNC      = 2;
  localparam int unsigned DEF_V_VIS_START = 35;
  localparam int unsigned DEF_V_VIS_END   = 515;

  // Half-open window test: lo <= x < hi, unsigned.
  function automatic logic in_window(input logic [CNT_W-1:0] x,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (x >= lo) && (x < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Timing bundle broadcast from the generator to the pixel-colour stages.
// Pure broadcast: no valid/ready, consumers sample every clk and qualify
// counter movement with pixel_tick; there is no backpressure.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  logic             pixel_tick;
  logic [CNT_W-1:0] H_Counter_Value;
  logic [CNT_W-1:0] V_Counter_Value;
  logic             Hsync;
  logic             Vsync;
  logic             video_on;
  logic             frame_start;
  logic [7:0]       frame_count;

  modport master (
    output pixel_tick, H_Counter_Value, V_Counter_Value,
    output Hsync, Vsync, video_on, frame_start, frame_count
  );

  modport slave (
    input pixel_tick, H_Counter_Value, V_Counter_Value,
    input Hsync, Vsync, video_on, frame_start, frame_count
  );
endinterface

// File: rtl/vga_timing_gen_clk_enable_div.sv
// Pixel clock-enable: one-clk strobe every CLK_DIV board clocks.
// The strobe is registered and lands in the clk where div has just wrapped to 0.
module clk_enable_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic pixel_tick
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;

  // Free-running divider and its registered wrap strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div        <= '0;
      pixel_tick <= 1'b0;
    end else begin
      if (div == DIV_LAST) div <= '0;
      else                 div <= div + DIV_W'(1);
      pixel_tick <= (div == DIV_LAST);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: H/V pixel counters, sync/visible decodes and
// per-frame strobes. Decodes are taken from the next-state counters so
// every output changes on the same edge as the counters it describes.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV     = DEF_CLK_DIV,
  parameter int unsigned H_TOTAL     = DEF_H_TOTAL,
  parameter int unsigned H_SYNC      = DEF_H_SYNC,
  parameter int unsigned H_VIS_START = DEF_H_VIS_START,
  parameter int unsigned H_VIS_END   = DEF_H_VIS_END,
  parameter int unsigned V_TOTAL     = DEF_V_TOTAL,
  parameter int unsigned V_SYNC      = DEF_V_SYNC,
  parameter int unsigned V_VIS_START = DEF_V_VIS_START,
  parameter int unsigned V_VIS_END   = DEF_V_VIS_END
) (
  input  logic             clk,
  input  logic             rst_n,
  vga_timing_gen_if.master vif
);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  logic             pixel_tick;
  logic [CNT_W-1:0] h_q, v_q, h_nxt, v_nxt;
  logic             frame_wrap;
  logic             hsync_q, vsync_q, video_on_q, frame_start_q;
  logic [7:0]       frame_count_q;

  clk_enable_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .pixel_tick (pixel_tick)
  );

  // Next-state counters: advance on the pixel strobe, H wrap carries into V.
  always_comb begin
    h_nxt      = h_q;
    v_nxt      = v_q;
    frame_wrap = 1'b0;
    if (pixel_tick) begin
      if (h_q == H_LAST) begin
        h_nxt = '0;
        if (v_q == V_LAST) begin
          v_nxt      = '0;
          frame_wrap = 1'b1;
        end else begin
          v_nxt = v_q + CNT_W'(1);
        end
      end else begin
        h_nxt = h_q + CNT_W'(1);
      end
    end
  end

  // Counter state plus decodes registered from the next-state values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q           <= '0;
      v_q           <= '0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      video_on_q    <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      h_q           <= h_nxt;
      v_q           <= v_nxt;
      hsync_q       <= (h_nxt >= CNT_W'(H_SYNC));
      vsync_q       <= (v_nxt >= CNT_W'(V_SYNC));
      video_on_q    <= in_window(h_nxt, CNT_W'(H_VIS_START), CNT_W'(H_VIS_END)) &&
                       in_window(v_nxt, CNT_W'(V_VIS_START), CNT_W'(V_VIS_END));
      frame_start_q <= frame_wrap;
      if (frame_wrap) frame_count_q <= frame_count_q + 8'd1;
    end
  end

  assign vif.pixel_tick      = pixel_tick;
  assign vif.H_Counter_Value = h_q;
  assign vif.V_Counter_Value = v_q;
  assign vif.Hsync           = hsync_q;
  assign vif.Vsync           = vsync_q;
  assign vif.video_on        = video_on_q;
  assign vif.frame_start     = frame_start_q;
  assign vif.frame_count     = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen using a shrunken raster so that 256 whole
// frames fit in a short run. Expected values come from a model that
// derives every output from the number of clocks since reset release.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  localparam int CD  = 4;
  localparam int HT  = 10;
  localparam int HS  = 2;
  localparam int HVS = 3;
  localparam int HVE = 9;
  localparam int VT  = 6;
  localparam int VS  = 2;
  localparam int VVS = 3;
  localparam int VVE = 5;
  localparam int FRAME_PIX  = HT * VT;
  localparam int FRAME_CLKS = FRAME_PIX * CD;

  typedef struct packed {
    logic             tick;
    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] v;
    logic             hs;
    logic             vs;
    logic             von;
    logic             fs;
    logic [7:0]       fc;
  } obs_t;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_timing_gen_if vif();

  vga_timing_gen #(
    .CLK_DIV(CD), .H_TOTAL(HT), .H_SYNC(HS), .H_VIS_START(HVS), .H_VIS_END(HVE),
    .V_TOTAL(VT), .V_SYNC(VS), .V_VIS_START(VVS), .V_VIS_END(VVE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .vif   (vif)
  );

  int k;      // posedges since the last reset release
  int total;
  int bad;
  logic [7:0] exp_q[$];

  // ---------------- reference model ----------------
  // p = pixels elapsed; the first strobe is at clock CD and counters
  // move on the following edge, so p = (k-1)/CD.
  function automatic obs_t model(input int kk);
    obs_t m;
    int p, hp, vp;
    p  = (kk == 0) ? 0 : (kk - 1) / CD;
    hp = p % HT;
    vp = (p / HT) % VT;
    m.tick = (kk > 0) && (kk % CD == 0);
    m.h    = CNT_W'(hp);
    m.v    = CNT_W'(vp);
    m.hs   = (hp >= HS);
    m.vs   = (vp >= VS);
    m.von  = (hp >= HVS) && (hp < HVE) && (vp >= VVS) && (vp < VVE);
    m.fs   = (kk > 0) && ((kk - 1) % CD == 0) && (p > 0) && (p % FRAME_PIX == 0);
    m.fc   = 8'((p / FRAME_PIX) % 256);
    return m;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.tick = vif.pixel_tick;
    o.h    = vif.H_Counter_Value;
    o.v    = vif.V_Counter_Value;
    o.hs   = vif.Hsync;
    o.vs   = vif.Vsync;
    o.von  = vif.video_on;
    o.fs   = vif.frame_start;
    o.fc   = vif.frame_count;
    return o;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    k = k + 1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    k = 0;
  endtask

  // Step until the counters first show (ht,vt); bounded by one frame.
  task automatic seek(input int ht, input int vt, output bit ok);
    bit prev, now;
    ok   = 1'b0;
    prev = (vif.H_Counter_Value == CNT_W'(ht)) && (vif.V_Counter_Value == CNT_W'(vt));
    for (int n = 0; n < FRAME_CLKS + 2 * CD; n++) begin
      step();
      now = (vif.H_Counter_Value == CNT_W'(ht)) && (vif.V_Counter_Value == CNT_W'(vt));
      if (now && !prev) begin
        ok = 1'b1;
        break;
      end
      prev = now;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL seek_timeout: point (%0d,%0d) not reached, now at (%0d,%0d)",
               ht, vt, vif.H_Counter_Value, vif.V_Counter_Value);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    obs_t obs, exp;
    int first;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    obs = observe();
    exp = model(0);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL reset_held: got %h want %h", obs, exp);
    end
    rst_n = 1'b1;
    k     = 0;
    first = -1;
    for (int i = 0; i < 12 * CD; i++) begin
      step();
      obs = observe();
      if (first < 0 && obs.tick) first = k;
      exp = model(k);
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL reset_release k=%0d: got %h want %h", k, obs, exp);
      end
    end
    total++;
    if (first !== CD) begin
      bad++;
      $display("FAIL first_tick: got clk %0d want clk %0d", first, CD);
    end
  endtask

  task automatic test_line_wrap();
    obs_t obs, exp;
    bit ok;
    int vt, cnt;
    vt = $urandom_range(VT - 2, 0);
    seek(HT - 1, vt, ok);
    repeat (CD) step();
    obs = observe();
    total++;
    if (obs.h !== CNT_W'(0) || obs.v !== CNT_W'(vt + 1)) begin
      bad++;
      $display("FAIL line_wrap: got (%0d,%0d) want (0,%0d)", obs.h, obs.v, vt + 1);
    end
    cnt = 0;
    for (int i = 0; i < HT * CD; i++) begin
      if (!vif.Hsync) cnt++;
      obs = observe();
      exp = model(k);
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL line_scan k=%0d: got %h want %h", k, obs, exp);
      end
      step();
    end
    total++;
    if (cnt != HS * CD) begin
      bad++;
      $display("FAIL hsync_width: got %0d clks want %0d clks", cnt, HS * CD);
    end
  endtask

  task automatic test_window();
    obs_t obs, exp;
    bit ok;
    int n;
    int pt_h[5] = '{HVS - 1, HVS, HVE - 1, HVE, HVS + 1};
    int pt_v[5] = '{VVS, VVS, VVE - 1, VVE - 1, VVE};
    bit pt_e[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    n = $urandom_range(2 * FRAME_CLKS, FRAME_CLKS);
    for (int i = 0; i < n; i++) begin
      step();
      obs = observe();
      exp = model(k);
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL window_run k=%0d: got %h want %h", k, obs, exp);
      end
    end
    for (int i = 0; i < 5; i++) begin
      seek(pt_h[i], pt_v[i], ok);
      total++;
      if (vif.video_on !== pt_e[i]) begin
        bad++;
        $display("FAIL video_on_at(%0d,%0d): got %b want %b",
                 pt_h[i], pt_v[i], vif.video_on, pt_e[i]);
      end
    end
    seek(HT - 1, VS - 1, ok);
    total++;
    if (vif.Vsync !== 1'b0) begin
      bad++;
      $display("FAIL vsync_last_sync_line: got %b want 0", vif.Vsync);
    end
    seek(0, VS, ok);
    total++;
    if (vif.Vsync !== 1'b1) begin
      bad++;
      $display("FAIL vsync_after_sync: got %b want 1", vif.Vsync);
    end
  endtask

  task automatic test_frame_wrap();
    obs_t obs, exp;
    int pulses;
    logic [7:0] want;
    do_reset();
    exp_q.delete();
    for (int f = 1; f <= 256; f++) exp_q.push_back(8'(f % 256));
    pulses = 0;
    for (int n = 0; n < 256 * FRAME_CLKS + 4 * CD && exp_q.size() > 0; n++) begin
      step();
      obs = observe();
      exp = model(k);
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL frame_run k=%0d: got %h want %h", k, obs, exp);
      end
      if (obs.fs) begin
        pulses++;
        want = exp_q.pop_front();
        total++;
        if (obs.fc !== want || obs.h !== CNT_W'(0) || obs.v !== CNT_W'(0)) begin
          bad++;
          $display("FAIL frame_pulse %0d: got fc=%0d at (%0d,%0d) want fc=%0d at (0,0)",
                   pulses, obs.fc, obs.h, obs.v, want);
        end
      end
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL frame_count_pulses: got %0d want 256", pulses);
    end
    step();
    total++;
    if (vif.frame_start !== 1'b0 || vif.frame_count !== 8'd0) begin
      bad++;
      $display("FAIL frame_after_256: got fs=%b fc=%0d want fs=0 fc=0",
               vif.frame_start, vif.frame_count);
    end
  endtask

  task automatic test_mid_reset();
    obs_t obs, exp;
    bit ok, fs_seen;
    int ht, vt;
    ht = $urandom_range(HT - 1, 1);
    vt = $urandom_range(VT - 1, 1);
    seek(ht, vt, ok);
    #2;
    rst_n = 1'b0;
    #1;
    obs = observe();
    exp = model(0);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL mid_reset_async: got %h want %h", obs, exp);
    end
    @(negedge clk);
    rst_n   = 1'b1;
    k       = 0;
    fs_seen = 1'b0;
    for (int i = 0; i < FRAME_CLKS; i++) begin
      step();
      obs = observe();
      if (obs.fs) fs_seen = 1'b1;
      exp = model(k);
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL mid_reset_restart k=%0d: got %h want %h", k, obs, exp);
      end
    end
    total++;
    if (fs_seen) begin
      bad++;
      $display("FAIL mid_reset_no_frame_start: got a pulse want none");
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    k     = 0;
    total = 0;
    bad   = 0;
    test_reset();
    test_line_wrap();
    test_window();
    test_frame_wrap();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
